// File: rtl/ble_whiten_par.sv
// Multi-bit-per-cycle BLE data whitening (x^7+x^4+1), DATA_WIDTH bits per beat, LSB first on air.
// Per-packet channel seed, header skip length and bypass are latched at load; 1-cycle latency.
module ble_whiten_par #(
  parameter int DATA_WIDTH               = 8,
  parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int SKIP_BIT_WIDTH           = 9,
  parameter int NBITS_WIDTH              = $clog2(DATA_WIDTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
  input  logic                                channel_number_load,
  input  logic [SKIP_BIT_WIDTH-1:0]           skip_bits,
  input  logic                                whiten_en,
  input  logic [DATA_WIDTH-1:0]               data_in,
  input  logic                                data_in_valid,
  input  logic                                data_in_valid_last,
  input  logic [NBITS_WIDTH-1:0]              data_in_nbits,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                data_out_valid,
  output logic                                data_out_valid_last,
  output logic [NBITS_WIDTH-1:0]              data_out_nbits,
  output logic                                busy,
  output logic                                load_err
);

  typedef enum logic [1:0] {IDLE, SKIP, WHITEN} state_t;

  localparam logic [31:0] CNT_MAX = 32'((1 << SKIP_BIT_WIDTH) - 1);

  // lfsr bit k holds position s_k; s6 is the keystream tap
  function automatic logic [6:0] lfsr_seed(input logic [5:0] ch);
    lfsr_seed = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    lfsr_step = {s[5], s[4], s[3] ^ s[6], s[2], s[1], s[0], s[6]};
  endfunction

  state_t                    state_q, state_d;
  logic [SKIP_BIT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [6:0]                lfsr_q, lfsr_d;
  logic [5:0]                chan_q, chan_d;
  logic [SKIP_BIT_WIDTH-1:0] skip_q, skip_d;
  logic                      wen_q, wen_d;

  logic [DATA_WIDTH-1:0]     data_p1, data_d;
  logic                      vld_p1, last_p1, load_err_p1, load_err_d;
  logic [NBITS_WIDTH-1:0]    nbits_p1;

  logic                      fin, load_now, load_late;
  logic [SKIP_BIT_WIDTH-1:0] skip_eff;
  logic                      wen_eff;
  logic [6:0]                lfsr_c;
  logic [31:0]               sum;
  int                        nb_eff;

  always_comb begin
    fin        = data_in_valid && data_in_valid_last;
    load_now   = channel_number_load && (state_q == IDLE);
    load_late  = channel_number_load && (state_q != IDLE) && fin;
    load_err_d = channel_number_load && (state_q != IDLE) && !fin;
    skip_eff   = load_now ? skip_bits : skip_q;
    wen_eff    = load_now ? whiten_en : wen_q;

    if (!data_in_valid)
      nb_eff = 0;
    else if (data_in_valid_last && (data_in_nbits != '0) &&
             (32'(data_in_nbits) <= 32'(DATA_WIDTH)))
      nb_eff = int'(data_in_nbits);
    else
      nb_eff = DATA_WIDTH;

    // unrolled keystream chain: one LFSR step per whitened bit
    lfsr_c = load_now ? lfsr_seed(channel_number[5:0]) : lfsr_q;
    data_d = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < nb_eff) begin
        if (wen_eff && (32'(bit_cnt_q) + 32'(i) >= 32'(skip_eff))) begin
          data_d[i] = data_in[i] ^ lfsr_c[6];
          lfsr_c    = lfsr_step(lfsr_c);
        end else begin
          data_d[i] = data_in[i];
        end
      end
    end

    sum       = 32'(bit_cnt_q) + 32'(nb_eff);
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    lfsr_d    = lfsr_q;
    chan_d    = chan_q;
    skip_d    = skip_q;
    wen_d     = wen_q;

    if (load_now || load_late) begin
      chan_d = channel_number[5:0];
      skip_d = skip_bits;
      wen_d  = whiten_en;
    end

    if (fin) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      lfsr_d    = lfsr_seed((load_now || load_late) ? channel_number[5:0] : chan_q);
    end else if (data_in_valid) begin
      bit_cnt_d = (sum > CNT_MAX) ? CNT_MAX[SKIP_BIT_WIDTH-1:0] : sum[SKIP_BIT_WIDTH-1:0];
      lfsr_d    = lfsr_c;
      if (state_q != WHITEN)
        state_d = (sum < 32'(skip_eff)) ? SKIP : WHITEN;
    end else if (load_now) begin
      lfsr_d = lfsr_seed(channel_number[5:0]);
    end
  end

  // stage p0 -> p1: control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      lfsr_q      <= 7'b0000001;
      chan_q      <= '0;
      skip_q      <= SKIP_BIT_WIDTH'(40);
      wen_q       <= 1'b1;
      data_p1     <= '0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      nbits_p1    <= '0;
      load_err_p1 <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      lfsr_q      <= lfsr_d;
      chan_q      <= chan_d;
      skip_q      <= skip_d;
      wen_q       <= wen_d;
      data_p1     <= data_d;
      vld_p1      <= data_in_valid;
      last_p1     <= data_in_valid_last;
      nbits_p1    <= NBITS_WIDTH'(nb_eff);
      load_err_p1 <= load_err_d;
    end
  end

  assign data_out            = data_p1;
  assign data_out_valid      = vld_p1;
  assign data_out_valid_last = last_p1;
  assign data_out_nbits      = nbits_p1;
  assign load_err            = load_err_p1;
  assign busy                = (state_q != IDLE);

endmodule
